axil_to_reg_mux: RTL
====================

# axil_to_reg_mux

Parametrised AXI-Lite slave that terminates all AXI-Lite handshaking and fans transactions out to `NUM_PORTS` simple register-slave ports, each owning a fixed power-of-two address window. It adds independent AW/W acceptance (either order or the same cycle), address decode with DECERR, and a read-response timeout returning SLVERR. It sits between the CPM/PL AXI-Lite interconnect and the per-function register files.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: data width, a multiple of 8.
- `NUM_PORTS`, 4: number of register ports, 1..16.
- `PORT_ADDR_BITS`, 12: log2 of the byte window per port.
- `BASE_ADDR`, 0: byte address of port 0's window, aligned to 2^PORT_ADDR_BITS.
- `TIMEOUT_CYCLES`, 255: maximum wait for a port `rvalid`, 1..65535.

Ports:
- `aclk` in 1: clock.
- `aresetn` in 1: reset. One clock; reset is asynchronous and active-low.
- AXI-Lite slave:
  - `s_axil_aw{valid,ready,addr,prot}` in/out/in/in, widths 1/1/ADDR_WIDTH/3.
  - `s_axil_w{valid,ready,data,strb}` in/out/in/in, widths 1/1/DATA_WIDTH/DATA_WIDTH/8.
  - `s_axil_b{valid,ready,resp}` out/in/out, widths 1/1/2.
  - `s_axil_ar{valid,ready,addr,prot}` in/out/in/in, widths 1/1/ADDR_WIDTH/3.
  - `s_axil_r{valid,ready,data,resp}` out/in/out/out, widths 1/1/DATA_WIDTH/2.
- Register master:
  - `wen` out NUM_PORTS: one-hot write strobe.
  - `waddr` out PORT_ADDR_BITS: byte offset in the window.
  - `wdata` out DATA_WIDTH.
  - `wbe` out DATA_WIDTH/8.
  - `ren` out NUM_PORTS: one-hot read request pulse.
  - `raddr` out PORT_ADDR_BITS: byte offset.
  - `rvalid` in NUM_PORTS: per-port read data valid, held until `rdone`.
  - `rdata` in NUM_PORTS*DATA_WIDTH: port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
  - `rdone` out NUM_PORTS: one-hot consume pulse.

## Operation
- Decode: `off = addr - BASE_ADDR`; `idx = off >> PORT_ADDR_BITS`.
  - The address is in error if `addr < BASE_ADDR` or `idx >= NUM_PORTS`.
  - Local offset is `addr[PORT_ADDR_BITS-1:0]`.
  - `*prot` is ignored.
- Write FSM:
  - WR_IDLE: `awready` and `wready` stay high until their own handshake, then each drops independently. Address, data and strobe are latched. When both have been captured (including the same-cycle case), go to WR_ISSUE.
  - WR_ISSUE (1 cycle): `wen[idx]=1`, with `waddr`, `wdata` and `wbe` driven from the latches. On decode error, `wen` stays 0. Then go to WR_RESP.
  - WR_RESP: `bvalid=1`, `bresp` is OKAY (00) or DECERR (11). On the `bready` handshake, go to WR_IDLE, which re-raises both readies.
- Read FSM:
  - RD_IDLE: `arready=1`. On the AR handshake, latch the address and go to RD_ISSUE.
  - RD_ISSUE (1 cycle): `ren[idx]=1`, `raddr` is driven. On decode error, `ren` stays 0 and the FSM goes to RD_RESP with DECERR and `rdata=0`. Otherwise it clears the timeout counter and goes to RD_WAIT.
  - RD_WAIT: when `rvalid[idx]=1`, `rdone[idx]=1` in the same cycle (combinational), `rdata` slice is latched, resp is OKAY, and the FSM goes to RD_RESP.
  - Timeout: the counter increments each RD_WAIT cycle. When it reaches TIMEOUT_CYCLES without `rvalid`, go to RD_RESP with SLVERR (10) and `rdata=0`.
  - RD_RESP: `s_axil_rvalid=1`, data and resp come from registers. On the `rready` handshake, go to RD_IDLE.
- Stale-response flush: in RD_IDLE, any asserted `rvalid[i]` (a late reply after a timeout) gets `rdone[i]=1` and is discarded. Outside RD_IDLE, `rdone[i]` is asserted only for the selected port in RD_WAIT.
- Read and write paths are fully independent. Each allows one outstanding transaction. Both may target the same port in the same cycle; ordering between them is undefined.
- Reset values: `awready=1`, `wready=1`, `arready=1`, `bvalid=0`, `rvalid=0`. `wen`, `ren` and `rdone` are 0. Both FSMs are IDLE; latches, `resp` and `rdata` are 0.
- Reset mid-transaction aborts it. No `wen`/`ren` is issued after reset, and port `rvalid` is flushed afterwards.

## Timing
- Write: last of the AW/W handshakes at cycle T → `wen` at T+1 → `bvalid` at T+2.
- Read: AR handshake at T → `ren` at T+1 → earliest `rvalid` sample at T+2 → `s_axil_rvalid` at T+3.
- Decode-error read: `s_axil_rvalid` at T+2.
- Timeout: `s_axil_rvalid` at T+2+TIMEOUT_CYCLES+1.
- Readies: low from the handshake through the response handshake. A new AW/AR is accepted in the cycle after B/R completes.
- `wen`, `ren` and `rdone` are single-cycle pulses and are never multi-hot.

## Structure
- Package `axil_reg_pkg` holds:
  - `RESP_OKAY`, `RESP_SLVERR`, `RESP_DECERR`.
  - `wr_state_t {WR_IDLE, WR_ISSUE, WR_RESP}`.
  - `rd_state_t {RD_IDLE, RD_ISSUE, RD_WAIT, RD_RESP}`.
- Sub-module `axil_addr_decode`: combinational, one instance each for the AW and AR latches. Outputs `idx`, `offset` and `err`.

## Test plan
- AW at T, W at T+3, addr `BASE+0x1004`, data `0xDEADBEEF`, strb `0xF`, for port 1 → `wen=0b0010` at T+4 with `waddr=0x004`, then `bvalid` with OKAY. Repeat with W before AW and with AW/W in the same cycle.
- Read `BASE+0x2008`, port 2 returns `rvalid` two cycles after `ren` with `0x12345678` → one `rdone[2]` pulse, then `rdata=0x12345678`, OKAY.
- Read and write to `BASE+NUM_PORTS<<12`, and an address below BASE → no `wen`/`ren`, resp DECERR (11), `rdata=0`.
- Port 0 never answers with TIMEOUT_CYCLES=8 → SLVERR, `rdata=0`. A late `rvalid[0]` afterwards gets flushed by `rdone[0]`, and the next read returns correct data.
- Hold `bready=0` and `rready=0` for 10 cycles → `bvalid`/`rvalid` stay high with stable data and readies stay low. Overlapping read and write complete independently.
- Assert `aresetn` low in RD_WAIT and in WR_RESP → all outputs return to their reset values immediately (asynchronously), and the next transaction completes normally.

Source files
------------

// File: rtl/axil_reg_pkg.sv
// Shared response codes and FSM state types for the
// AXI-Lite to register-port bridge.
package axil_reg_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_ISSUE,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_ISSUE,
    RD_WAIT,
    RD_RESP
  } rd_state_t;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/axil_addr_decode.sv
// Maps a byte address onto a port index and window offset,
// flagging addresses outside the populated windows.
module axil_addr_decode
  import axil_reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int NUM_PORTS      = 4,
  parameter int PORT_ADDR_BITS = 12,
  parameter int IDX_W          = idx_width(NUM_PORTS),
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
  input  logic [ADDR_WIDTH-1:0]     addr,
  output logic [IDX_W-1:0]          idx,
  output logic [PORT_ADDR_BITS-1:0] offset,
  output logic                      err
);

  logic [ADDR_WIDTH-1:0] off;
  logic [ADDR_WIDTH-1:0] blk;

  assign off = addr - BASE_ADDR;
  assign blk = off >> PORT_ADDR_BITS;

  assign err = (addr < BASE_ADDR) ||
               (blk >= ADDR_WIDTH'(NUM_PORTS));

  assign idx    = blk[IDX_W-1:0];
  assign offset = addr[PORT_ADDR_BITS-1:0];

endmodule

// File: rtl/axil_to_reg_mux.sv
// AXI-Lite slave fanning single transactions out to
// NUM_PORTS simple register ports with decode/timeout errors.
module axil_to_reg_mux
  import axil_reg_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_PORTS      = 4,
  parameter int PORT_ADDR_BITS = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      aclk,
  input  logic                      aresetn,

  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_awaddr,
  input  logic [2:0]                s_axil_awprot,

  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  input  logic [DATA_WIDTH-1:0]     s_axil_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s_axil_wstrb,

  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  output logic [1:0]                s_axil_bresp,

  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  input  logic [ADDR_WIDTH-1:0]     s_axil_araddr,
  input  logic [2:0]                s_axil_arprot,

  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [DATA_WIDTH-1:0]     s_axil_rdata,
  output logic [1:0]                s_axil_rresp,

  output logic [NUM_PORTS-1:0]      wen,
  output logic [PORT_ADDR_BITS-1:0] waddr,
  output logic [DATA_WIDTH-1:0]     wdata,
  output logic [DATA_WIDTH/8-1:0]   wbe,

  output logic [NUM_PORTS-1:0]      ren,
  output logic [PORT_ADDR_BITS-1:0] raddr,
  input  logic [NUM_PORTS-1:0]      rvalid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] rdata,
  output logic [NUM_PORTS-1:0]      rdone
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = idx_width(NUM_PORTS);
  localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

  logic unused_prot;
  assign unused_prot = ^{s_axil_awprot, s_axil_arprot};

  wr_state_t wr_state, wr_next;
  logic                  aw_done, w_done;
  logic                  aw_hs, w_hs;
  logic [ADDR_WIDTH-1:0] aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic [IDX_W-1:0]      w_idx;
  logic                  w_err;

  axil_addr_decode #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_PORTS      (NUM_PORTS),
    .PORT_ADDR_BITS (PORT_ADDR_BITS),
    .IDX_W          (IDX_W),
    .BASE_ADDR      (BASE_ADDR)
  ) u_aw_dec (
    .addr   (aw_addr),
    .idx    (w_idx),
    .offset (waddr),
    .err    (w_err)
  );

  assign s_axil_awready = (wr_state == WR_IDLE) && !aw_done;
  assign s_axil_wready  = (wr_state == WR_IDLE) && !w_done;
  assign aw_hs = s_axil_awvalid && s_axil_awready;
  assign w_hs  = s_axil_wvalid && s_axil_wready;
  assign wdata = w_data;
  assign wbe   = w_strb;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state <= WR_IDLE;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
      aw_addr  <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      wr_state <= wr_next;
      if (aw_hs) begin
        aw_done <= 1'b1;
        aw_addr <= s_axil_awaddr;
      end
      if (w_hs) begin
        w_done <= 1'b1;
        w_data <= s_axil_wdata;
        w_strb <= s_axil_wstrb;
      end
      // Readies come back only once the response is taken
      if (wr_state == WR_RESP && s_axil_bready) begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
    end
  end

  always_comb begin
    wr_next       = wr_state;
    wen           = '0;
    s_axil_bvalid = 1'b0;
    s_axil_bresp  = RESP_OKAY;
    unique case (wr_state)
      WR_IDLE: begin
        if ((aw_done || aw_hs) && (w_done || w_hs))
          wr_next = WR_ISSUE;
      end
      WR_ISSUE: begin
        if (!w_err)
          wen = NUM_PORTS'(1) << w_idx;
        wr_next = WR_RESP;
      end
      WR_RESP: begin
        s_axil_bvalid = 1'b1;
        s_axil_bresp  = w_err ? RESP_DECERR : RESP_OKAY;
        if (s_axil_bready)
          wr_next = WR_IDLE;
      end
      default: wr_next = WR_IDLE;
    endcase
  end

  rd_state_t rd_state, rd_next;
  logic                  ar_hs;
  logic [ADDR_WIDTH-1:0] ar_addr;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_err;
  logic                  r_hit;
  logic                  tmo_hit;
  logic [15:0]           tmo_cnt;
  logic [DATA_WIDTH-1:0] r_slice;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [1:0]            rresp_q;

  axil_addr_decode #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .NUM_PORTS      (NUM_PORTS),
    .PORT_ADDR_BITS (PORT_ADDR_BITS),
    .IDX_W          (IDX_W),
    .BASE_ADDR      (BASE_ADDR)
  ) u_ar_dec (
    .addr   (ar_addr),
    .idx    (r_idx),
    .offset (raddr),
    .err    (r_err)
  );

  assign s_axil_arready = (rd_state == RD_IDLE);
  assign s_axil_rvalid  = (rd_state == RD_RESP);
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = rresp_q;
  assign ar_hs   = s_axil_arvalid && s_axil_arready;
  assign r_hit   = rvalid[r_idx];
  assign tmo_hit = (tmo_cnt == TMO);
  assign r_slice = rdata[int'(r_idx)*DATA_WIDTH +: DATA_WIDTH];

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rd_state <= RD_IDLE;
      ar_addr  <= '0;
      tmo_cnt  <= '0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else begin
      rd_state <= rd_next;
      if (ar_hs)
        ar_addr <= s_axil_araddr;
      if (rd_state == RD_ISSUE) begin
        tmo_cnt <= '0;
        if (r_err) begin
          rdata_q <= '0;
          rresp_q <= RESP_DECERR;
        end
      end
      if (rd_state == RD_WAIT) begin
        if (r_hit) begin
          rdata_q <= r_slice;
          rresp_q <= RESP_OKAY;
        end else if (tmo_hit) begin
          rdata_q <= '0;
          rresp_q <= RESP_SLVERR;
        end else begin
          tmo_cnt <= tmo_cnt + 16'd1;
        end
      end
    end
  end

  always_comb begin
    rd_next = rd_state;
    ren     = '0;
    rdone   = '0;
    unique case (rd_state)
      RD_IDLE: begin
        // Late replies from timed-out reads are drained here
        rdone = rvalid;
        if (ar_hs)
          rd_next = RD_ISSUE;
      end
      RD_ISSUE: begin
        if (!r_err) begin
          ren     = NUM_PORTS'(1) << r_idx;
          rd_next = RD_WAIT;
        end else begin
          rd_next = RD_RESP;
        end
      end
      RD_WAIT: begin
        if (r_hit) begin
          rdone   = NUM_PORTS'(1) << r_idx;
          rd_next = RD_RESP;
        end else if (tmo_hit) begin
          rd_next = RD_RESP;
        end
      end
      RD_RESP: begin
        if (s_axil_rready)
          rd_next = RD_IDLE;
      end
      default: rd_next = RD_IDLE;
    endcase
  end

endmodule
